// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter: arbitrates two requesters onto a single-port register file
// and returns read data to the issuer. Define REG_ARB_FIXED_PRIO_EN for fixed priority.
//
// Handshake: a requester raises reqN with weN/idN/wdataN and holds them stable
// until it observes gntN. The command is accepted at the edge that ends the gnt
// cycle; from there the requester either drops reqN or presents its next command.
// Reads complete with a single-cycle rvalidN, and rdataN holds until the next read.
module reg_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ID_W-1:0]   id0,
  input  logic [ID_W-1:0]   id1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              reg_rd,
  output logic              reg_wn,
  output logic [ID_W-1:0]   reg_id,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_take;
  logic                w_win;
  logic                w_we;
  logic [ID_W-1:0]     w_id;
  logic [DATA_W-1:0]   w_wdata;

  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_busy;
  logic                r_reg_rd;
  logic                r_reg_wn;
  logic [ID_W-1:0]     r_reg_id;
  logic [DATA_W-1:0]   r_reg_wdata;
  logic                r_owner;

`ifndef REG_ARB_FIXED_PRIO_EN
  logic                r_last;
`endif

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_win        = 1'b0;
`ifdef REG_ARB_FIXED_PRIO_EN
    w_win = ~req0;
`else
    // On a tie the requester that did not win last time goes next.
    w_win = (req0 & req1) ? ~r_last : req1;
`endif
    case (r_state)
      S_IDLE: begin
        if (req0 | req1) begin
          w_take       = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: w_state_next = r_reg_wn ? S_IDLE : S_WAIT;
      S_WAIT:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_we    = w_win ? we1    : we0;
  assign w_id    = w_win ? id1    : id0;
  assign w_wdata = w_win ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_busy      <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_reg_wn    <= 1'b0;
      r_reg_id    <= '0;
      r_reg_wdata <= '0;
      r_owner     <= 1'b0;
    end else begin
      r_gnt0    <= w_take & ~w_win;
      r_gnt1    <= w_take & w_win;
      r_reg_rd  <= w_take & ~w_we;
      r_reg_wn  <= w_take & w_we;
      r_busy    <= (w_state_next != S_IDLE);
      r_rvalid0 <= (r_state == S_WAIT) & ~r_owner;
      r_rvalid1 <= (r_state == S_WAIT) & r_owner;
      if (w_take) begin
        r_reg_id    <= w_id;
        r_reg_wdata <= w_wdata;
        r_owner     <= w_win;
      end
      // Register file data is valid in WAIT, one cycle after the read strobe.
      if (r_state == S_WAIT) begin
        if (r_owner) r_rdata1 <= reg_rdata;
        else         r_rdata0 <= reg_rdata;
      end
    end
  end

`ifndef REG_ARB_FIXED_PRIO_EN
  // Reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_last <= 1'b1;
    else if (w_take) r_last <= w_win;
  end
`endif

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign busy      = r_busy;
  assign reg_rd    = r_reg_rd;
  assign reg_wn    = r_reg_wn;
  assign reg_id    = r_reg_id;
  assign reg_wdata = r_reg_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: directed commands, grant/read scoreboard, and a
// small register-file model behind the port.
module tb_reg_port_arbiter;
  localparam int DW = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [IW-1:0] id0 = '0, id1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, reg_rd, reg_wn;
  logic [DW-1:0] rdata0, rdata1, reg_wdata;
  logic [DW-1:0] reg_rdata = '0;
  logic [IW-1:0] reg_id;
  logic [1:0]    dbg_state;

  reg_port_arbiter #(.DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .id0(id0), .id1(id1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .reg_rd(reg_rd), .reg_wn(reg_wn), .reg_id(reg_id), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .dbg_state(dbg_state)
  );

  // Clock / reset-independent environment: clock, cycle count, register file.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (reg_wn) mem[reg_id] <= reg_wdata;
    if (reg_rd) reg_rdata <= mem[reg_id];
  end

  typedef struct packed {
    logic          we;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t          cmdq0[$];
  cmd_t          cmdq1[$];
  logic [21:0]   exp_q[$];
  logic [DW-1:0] exp_rd0_q[$];
  logic [DW-1:0] exp_rd1_q[$];
  int            gnt_cyc_q[$];
  logic          gnt_who_q[$];
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_gnt(input logic n, input logic we, input logic [IW-1:0] id,
                            input logic [DW-1:0] data);
    exp_q.push_back({n, we, id, data});
  endtask

  task automatic clear_log();
    gnt_cyc_q.delete();
    gnt_who_q.delete();
  endtask

  // Monitor: compares every grant and read return against the scoreboard.
  task automatic monitor();
    logic [21:0]   e;
    logic [DW-1:0] d;
    logic          n;
    forever begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        n = gnt1;
        check("gnt_both", {31'd0, gnt0 & gnt1}, 32'd0);
        check("gnt_busy", {31'd0, busy}, 32'd1);
        gnt_cyc_q.push_back(cyc);
        gnt_who_q.push_back(n);
        check("gnt_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("gnt_who", {31'd0, n}, {31'd0, e[21]});
          check("gnt_wn", {31'd0, reg_wn}, {31'd0, e[20]});
          check("gnt_rd", {31'd0, reg_rd}, {31'd0, ~e[20]});
          check("gnt_id", {28'd0, reg_id}, {28'd0, e[19:16]});
          if (e[20]) check("gnt_wdata", {16'd0, reg_wdata}, {16'd0, e[15:0]});
        end
      end
      if (rvalid0) begin
        check("rv0_busy", {31'd0, busy}, 32'd0);
        check("rv0_expected", {31'd0, exp_rd0_q.size() != 0}, 32'd1);
        if (exp_rd0_q.size() != 0) begin
          d = exp_rd0_q.pop_front();
          check("rv0_data", {16'd0, rdata0}, {16'd0, d});
        end
      end
      if (rvalid1) begin
        check("rv1_busy", {31'd0, busy}, 32'd0);
        check("rv1_expected", {31'd0, exp_rd1_q.size() != 0}, 32'd1);
        if (exp_rd1_q.size() != 0) begin
          d = exp_rd1_q.pop_front();
          check("rv1_data", {16'd0, rdata1}, {16'd0, d});
        end
      end
    end
  endtask

  task automatic drive(input int n, input cmd_t c);
    if (n == 0) begin
      req0 = 1'b1; we0 = c.we; id0 = c.id; wdata0 = c.data;
    end else begin
      req1 = 1'b1; we1 = c.we; id1 = c.id; wdata1 = c.data;
    end
  endtask

  // Driver: presents queued commands back to back, each held until its grant.
  task automatic run_req(input int n);
    cmd_t c;
    int   t;
    logic g;
    forever begin
      if (n == 0) begin
        if (cmdq0.size() == 0) break;
        c = cmdq0.pop_front();
      end else begin
        if (cmdq1.size() == 0) break;
        c = cmdq1.pop_front();
      end
      drive(n, c);
      t = 0;
      do begin
        @(negedge clk);
        t++;
        g = (n == 0) ? gnt0 : gnt1;
      end while (!g && t < 60);
      check("gnt_timeout", {31'd0, g}, 32'd1);
      @(posedge clk);
      #1;
    end
    if (n == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic any_rv;
    fork
      monitor();
    join_none

    // Reset state
    #3 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    check("rst_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    check("rst_rdata", {rdata0, rdata1}, 32'd0);
    check("rst_strobe", {29'd0, busy, reg_rd, reg_wn}, 32'd0);
    check("rst_reg", {12'd0, reg_id, reg_wdata}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b1;
    idle(2);

    // Single write then read from requester 1, with latency checks
    req1 = 1'b1; we1 = 1'b1; id1 = 4'd3; wdata1 = 16'hBEEF;
    expect_gnt(1'b1, 1'b1, 4'd3, 16'hBEEF);
    @(negedge clk);
    check("wr_gnt_early", {31'd0, gnt1}, 32'd0);
    @(negedge clk);
    check("wr_gnt_lat", {29'd0, gnt1, reg_wn, gnt0}, 32'b110);
    check("wr_reg", {12'd0, reg_id, reg_wdata}, {12'd0, 4'd3, 16'hBEEF});
    @(posedge clk);
    #1 we1 = 1'b0;
    expect_gnt(1'b1, 1'b0, 4'd3, 16'h0000);
    exp_rd1_q.push_back(16'hBEEF);
    @(negedge clk);
    check("wr_clear", {29'd0, gnt1, reg_wn, busy}, 32'd0);
    @(negedge clk);
    check("rd_gnt_lat", {30'd0, gnt1, reg_rd}, 32'b11);
    @(posedge clk);
    #1 req1 = 1'b0;
    @(negedge clk);
    check("rd_rv_early", {30'd0, rvalid1, busy}, 32'b01);
    @(negedge clk);
    check("rd_rv_lat", {30'd0, rvalid1, rvalid0}, 32'b10);
    check("rd_rdata1", {16'd0, rdata1}, 32'h0000BEEF);
    @(negedge clk);
    check("rd_rv_pulse", {31'd0, rvalid1}, 32'd0);
    idle(2);

    // Read return routing
    cmdq0.push_back({1'b1, 4'd5, 16'h1234}); expect_gnt(1'b0, 1'b1, 4'd5, 16'h1234);
    run_req(0);
    cmdq1.push_back({1'b1, 4'd6, 16'h00FF}); expect_gnt(1'b1, 1'b1, 4'd6, 16'h00FF);
    run_req(1);
    cmdq0.push_back({1'b0, 4'd5, 16'h0}); expect_gnt(1'b0, 1'b0, 4'd5, 16'h0);
    exp_rd0_q.push_back(16'h1234);
    run_req(0);
    cmdq1.push_back({1'b0, 4'd6, 16'h0}); expect_gnt(1'b1, 1'b0, 4'd6, 16'h0);
    exp_rd1_q.push_back(16'h00FF);
    run_req(1);
    idle(6);
    check("route_hold", {rdata0, rdata1}, {16'h1234, 16'h00FF});

    // Back-to-back from requester 0: writes every 2 cycles, reads every 3
    clear_log();
    cmdq0.push_back({1'b1, 4'd7, 16'h0A0A}); expect_gnt(1'b0, 1'b1, 4'd7, 16'h0A0A);
    cmdq0.push_back({1'b1, 4'd8, 16'h0B0B}); expect_gnt(1'b0, 1'b1, 4'd8, 16'h0B0B);
    cmdq0.push_back({1'b0, 4'd7, 16'h0});    expect_gnt(1'b0, 1'b0, 4'd7, 16'h0);
    cmdq0.push_back({1'b0, 4'd8, 16'h0});    expect_gnt(1'b0, 1'b0, 4'd8, 16'h0);
    exp_rd0_q.push_back(16'h0A0A);
    exp_rd0_q.push_back(16'h0B0B);
    run_req(0);
    idle(6);
    check("b2b_count", gnt_cyc_q.size(), 32'd4);
    if (gnt_cyc_q.size() == 4) begin
      check("b2b_wr_gap", gnt_cyc_q[1] - gnt_cyc_q[0], 32'd2);
      check("b2b_wr_rd_gap", gnt_cyc_q[2] - gnt_cyc_q[1], 32'd2);
      check("b2b_rd_gap", gnt_cyc_q[3] - gnt_cyc_q[2], 32'd3);
    end

    // Tie arbitration straight after reset
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    idle(1);
    clear_log();
    cmdq0.push_back({1'b0, 4'd5, 16'h0});
    cmdq0.push_back({1'b0, 4'd6, 16'h0});
    cmdq1.push_back({1'b0, 4'd6, 16'h0});
    cmdq1.push_back({1'b0, 4'd3, 16'h0});
`ifdef REG_ARB_FIXED_PRIO_EN
    expect_gnt(1'b0, 1'b0, 4'd5, 16'h0);
    expect_gnt(1'b0, 1'b0, 4'd6, 16'h0);
    expect_gnt(1'b1, 1'b0, 4'd6, 16'h0);
    expect_gnt(1'b1, 1'b0, 4'd3, 16'h0);
`else
    expect_gnt(1'b0, 1'b0, 4'd5, 16'h0);
    expect_gnt(1'b1, 1'b0, 4'd6, 16'h0);
    expect_gnt(1'b0, 1'b0, 4'd6, 16'h0);
    expect_gnt(1'b1, 1'b0, 4'd3, 16'h0);
`endif
    exp_rd0_q.push_back(16'h1234);
    exp_rd0_q.push_back(16'h00FF);
    exp_rd1_q.push_back(16'h00FF);
    exp_rd1_q.push_back(16'hBEEF);
    fork
      run_req(0);
      run_req(1);
    join
    idle(6);
    check("tie_count", gnt_cyc_q.size(), 32'd4);
    if (gnt_cyc_q.size() == 4) begin
`ifdef REG_ARB_FIXED_PRIO_EN
      check("tie_order", {28'd0, gnt_who_q[0], gnt_who_q[1], gnt_who_q[2], gnt_who_q[3]}, 32'b0011);
`else
      check("tie_order", {28'd0, gnt_who_q[0], gnt_who_q[1], gnt_who_q[2], gnt_who_q[3]}, 32'b0101);
`endif
    end

    // Reset during WAIT of a requester-1 read
    req1 = 1'b1; we1 = 1'b0; id1 = 4'd3;
    expect_gnt(1'b1, 1'b0, 4'd3, 16'h0);
    @(negedge clk);
    @(negedge clk);
    check("mid_gnt", {31'd0, gnt1}, 32'd1);
    @(posedge clk);
    #1 req1 = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("mid_rst_ctl", {26'd0, busy, gnt0, gnt1, reg_rd, reg_wn, rvalid1}, 32'd0);
    check("mid_rst_data", {rdata0, rdata1}, 32'd0);
    check("mid_rst_reg", {12'd0, reg_id, reg_wdata}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    any_rv = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any_rv = any_rv | rvalid0 | rvalid1;
    end
    check("mid_no_rvalid", {31'd0, any_rv}, 32'd0);
    @(posedge clk);
    #1;
    clear_log();
    cmdq0.push_back({1'b1, 4'd9, 16'h1111});
    cmdq1.push_back({1'b1, 4'd10, 16'h2222});
    expect_gnt(1'b0, 1'b1, 4'd9, 16'h1111);
    expect_gnt(1'b1, 1'b1, 4'd10, 16'h2222);
    fork
      run_req(0);
      run_req(1);
    join
    idle(4);
    check("post_rst_count", gnt_cyc_q.size(), 32'd2);
    if (gnt_cyc_q.size() == 2)
      check("post_rst_tie", {30'd0, gnt_who_q[0], gnt_who_q[1]}, 32'b01);

    check("sb_gnt_empty", exp_q.size(), 32'd0);
    check("sb_rd_empty", exp_rd0_q.size() + exp_rd1_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_port_arbiter.md
# reg_port_arbiter

Arbiter and sequencer for the single-port register file. Two requesters share the port: requester 0 is instruction fetch and requester 1 is the host/debug loader. The block accepts one command at a time, drives the register file's `rd`/`wn`/`reg_id`/`write_data` pins for exactly one cycle, and returns read data to the requester that issued the command. It sits between the requesters and the `Register` instance, replacing the direct always-block wiring at the top level.

## Interface
Parameters:
- `DATA_W`, 16, register data width.
- `ID_W`, 4, register index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: command request, requester 0 / 1.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `id0`, `id1` in `ID_W`: register index.
- `wdata0`, `wdata1` in `DATA_W`: write data.
- `gnt0`, `gnt1` out 1: one-cycle grant pulse; the command has been issued this cycle.
- `rvalid0`, `rvalid1` out 1: one-cycle read-data-valid pulse.
- `rdata0`, `rdata1` out `DATA_W`: read data, held until the next read for that requester.
- `busy` out 1: state is not IDLE.
- `reg_rd`, `reg_wn` out 1: register file read / write strobe.
- `reg_id` out `ID_W`: register file index.
- `reg_wdata` out `DATA_W`: register file write data.
- `reg_rdata` in `DATA_W`: register file read data. It is valid the cycle after `reg_rd`.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE, with any `reqN` high at a clock edge:
  - Select the winner.
  - Register the winner's `idN`, `wdataN` and `weN` into `reg_id`, `reg_wdata`, `reg_rd = ~we`, `reg_wn = we`.
  - Set `gntN = 1`.
  - Go to ISSUE.
- IDLE, with no request: all strobes and grants stay 0.
- ISSUE:
  - Strobe and grant are high for this cycle only; cleared at the exit edge.
  - Write: go to IDLE.
  - Read: go to WAIT.
- WAIT: at the exit edge, capture `reg_rdata` into `rdataN` of the issuing requester and set `rvalidN = 1` for one cycle. Go to IDLE.
- Requester rules:
  - A requester holds `req`/`we`/`id`/`wdata` stable until it sees `gnt`.
  - At the edge ending the `gnt` cycle it either drops `req` or presents its next command.
  - A `req` still high when the block is back in IDLE is treated as a new command.
- Arbitration is round-robin.
  - A `last` register holds the previous winner.
  - Both requesting: the requester that is not `last` wins.
  - One requesting: that requester wins.
  - `last` updates only on a grant.
- `reg_id`, `reg_wdata` and `rdataN` are not cleared after use; they hold their last value.
- `rvalidN` and `gntN` never assert for the losing requester.

## Timing
- Reset (`reset = 0`, asynchronous):
  - State goes to IDLE and `last` to 1, so requester 0 wins the first tie.
  - All outputs go to 0: `gnt*`, `rvalid*`, `rdata*`, `busy`, `reg_rd`, `reg_wn`, `reg_id`, `reg_wdata`.
- Reset mid-operation aborts the command.
  - No `rvalid` is issued.
  - Strobes drop immediately.
  - A write is lost only if reset arrives before the ISSUE edge.
- Latency, counted from the edge that samples `req` in IDLE:
  - Grant and strobe: cycle +1.
  - Read data at the register file: cycle +2.
  - `rvalid`/`rdata`: cycle +3.
- Throughput:
  - Writes: one per 2 cycles (IDLE, ISSUE).
  - Reads: one per 3 cycles (IDLE, ISSUE, WAIT).
- Requests arriving in ISSUE or WAIT are not lost; they are sampled at the next IDLE edge.
- `busy` is registered and is high in ISSUE and WAIT.

## Configuration
- `REG_ARB_FIXED_PRIO_EN` defined: fixed priority. Requester 0 wins every tie, and the `last` register is not implemented.
- `REG_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described in Operation.

## Test plan
- Single write then read:
  - Stimulus: `req1` write id 3, data 0xBEEF; then read id 3.
  - Response: `gnt1` at +1 with `reg_wn = 1`, `reg_id = 3`, `reg_wdata = 0xBEEF`. For the read, `rvalid1` at +3 with `rdata1 = 0xBEEF`; `gnt0`/`rvalid0` stay 0.
- Tie arbitration, without the macro:
  - Stimulus: `req0`/`req1` both high continuously with reads.
  - Response: grants in order 0, 1, 0, 1. With `REG_ARB_FIXED_PRIO_EN` defined, the order is 0, 0, 0.
- Read return routing:
  - Stimulus: requester 0 reads id 5 holding 0x1234; requester 1 reads id 6 holding 0x00FF.
  - Response: `rdata0 = 0x1234` and `rdata1 = 0x00FF`, each with its own single-cycle `rvalid`.
- Back-to-back from one requester:
  - Stimulus: `req0` held high with new commands presented after each `gnt0`.
  - Response: writes are granted every 2 cycles, reads every 3. `busy` low only in IDLE cycles.
- Reset mid-read:
  - Stimulus: assert `reset = 0` during WAIT.
  - Response: all outputs 0 asynchronously; no `rvalid` after release; the next tie goes to requester 0.
